obj_table_mgr: RTL and testbench
================================

Name: obj_table_mgr

Overview:
- Parametrised successor to the fixed-content shape-object store feeding basic_graph.
- Holds up to MAX_LEN shape objects, edited at runtime through a valid/ready command port: add, set, delete-with-compaction, clear.
- Drives the packed object array and length consumed by the VGA renderer.
- Optional double buffering means edits become visible only at frame boundaries.

Parameters:
- OBJ_WIDTH, 66, object word width. Fields: [65:62] enum, [61:52] x, [51:42] y, [41:32] w, [31:22] h, [21:12] radius, [11:0] color.
- MAX_LEN, 16, table depth, ≥2.
- LEN_BITS, 6, width of length/index, must hold MAX_LEN.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0 ADD, 1 SET, 2 DEL, 3 CLEAR.
- cmd_idx  in  LEN_BITS  target index for SET/DEL.
- cmd_obj  in  OBJ_WIDTH  object for ADD/SET.
- cmd_err  out  1  one-cycle pulse: rejected command.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- commit_done  out  1  one-cycle pulse: visible table updated.
- obj_arr_packed  out  OBJ_WIDTH*MAX_LEN  entry i at [(i+1)*OBJ_WIDTH-1 : i*OBJ_WIDTH].
- arr_len  out  LEN_BITS  number of valid entries.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-low.
- Reset values:
  - All entries are 0 (NONE_ENUM). Length is 0.
  - cmd_err=0, commit_done=0, state=IDLE.
  - cmd_ready is 0 while rst=0.
- Reset mid-delete aborts the delete. The table returns to zero the next edge.
- Invariant: entries at index ≥ len are always all-zero. The renderer terminates on NONE_ENUM, so this must hold.
- cmd_ready = (state==IDLE) && rst. This is combinational from registered state.
- FSM states: IDLE and SHIFT.
- ADD (accept cycle):
  - If len<MAX_LEN: entry[len]<=cmd_obj and len<=len+1. Result is visible in the work table next cycle.
  - If len==MAX_LEN: no change, cmd_err pulses.
- SET (accept cycle):
  - If idx<len: entry[idx]<=cmd_obj.
  - Otherwise: no change, cmd_err pulses.
- DEL:
  - If idx≥len: cmd_err pulses and state stays IDLE.
  - Otherwise, on accept: capture ptr=idx and go to SHIFT.
  - Each SHIFT cycle: if ptr<len-1, entry[ptr]<=entry[ptr+1] and ptr++.
  - When ptr==len-1: entry[ptr]<=0, len<=len-1, return to IDLE.
  - Busy time is len-idx cycles. cmd_ready stays 0 throughout.
- CLEAR (accept cycle): all entries <=0 and len<=0, in one cycle. Never errors.
- cmd_err is registered. It asserts the cycle after the accept edge, for exactly one cycle.
- cmd_idx and cmd_obj are sampled only at accept.
- Command fields are don't-care when cmd_valid=0.

Optional Feature:
- Macro: OBJ_TABLE_DOUBLE_BUF_EN.
- When defined:
  - Commands edit a work table.
  - obj_arr_packed and arr_len come from a separate active copy.
  - frame_start sets a pending flag.
  - On the first clock where state==IDLE and no command is accepted, with pending set:
    - the active copy <= work table, including len, in one cycle;
    - pending clears;
    - commit_done pulses in the following cycle.
  - frame_start arriving while pending is set is absorbed: there is one commit.
  - frame_start coincident with an accept defers the commit; it does not drop it.
  - Reset clears both copies and pending.
- When undefined:
  - Outputs come directly from the work table.
  - frame_start is ignored.
  - commit_done is tied 0.

Decomposition:
- Package obj_pkg holds:
  - the enum constants (NONE/RECTANGLE/CIRCLE/ROUNDRECT);
  - the colour constants;
  - the field-slice MSB/LSB constants;
  - the cmd_op encodings.
- The same package replaces the loose macros in basic_graph.
- One natural sub-module: obj_table_core. It holds the work table, length and SHIFT FSM, and outputs packed work data.
- The top wraps obj_table_core with the optional shadow copy and commit logic.

Test Plan:
- Reset, then 3 ADDs (RECT red, CIRCLE green, ROUNDRECT white) -> arr_len=3, entries 0..2 match, entry 3 all zero, cmd_err never 1.
- Fill to 16 then ADD -> cmd_err single pulse, arr_len stays 16, table unchanged. SET idx=16 -> cmd_err, no change.
- Len=5, DEL idx=1 -> cmd_ready low 4 cycles, entries become {0,2,3,4}, entry 4 zero, arr_len=4. DEL idx=4 on len=4 -> cmd_err.
- DEL idx=0 on len=8, rst low mid-SHIFT -> next edge all entries 0, arr_len=0, cmd_ready 1 after release.
- With OBJ_TABLE_DOUBLE_BUF_EN: ADD two objects -> outputs unchanged (len 0). frame_start -> arr_len=2 and commit_done pulse. frame_start during DEL -> commit occurs in the first IDLE cycle after SHIFT completes, showing the post-delete table.
- Without macro: ADD -> arr_len increments the next cycle; frame_start pulses -> commit_done stays 0.

Source files
------------

// File: rtl/obj_pkg.sv
// Shared shape-object definitions: field slices, enum and colour constants,
// command opcodes and table FSM states. Used by obj_table_mgr and basic_graph.
package obj_pkg;

   localparam int OBJ_W      = 66;

   localparam int ENUM_MSB   = 65;
   localparam int ENUM_LSB   = 62;
   localparam int X_MSB      = 61;
   localparam int X_LSB      = 52;
   localparam int Y_MSB      = 51;
   localparam int Y_LSB      = 42;
   localparam int W_MSB      = 41;
   localparam int W_LSB      = 32;
   localparam int H_MSB      = 31;
   localparam int H_LSB      = 22;
   localparam int RADIUS_MSB = 21;
   localparam int RADIUS_LSB = 12;
   localparam int COLOR_MSB  = 11;
   localparam int COLOR_LSB  = 0;

   localparam logic [3:0] NONE_ENUM      = 4'd0;
   localparam logic [3:0] RECTANGLE_ENUM = 4'd1;
   localparam logic [3:0] CIRCLE_ENUM    = 4'd2;
   localparam logic [3:0] ROUNDRECT_ENUM = 4'd3;

   localparam logic [11:0] COLOR_BLACK = 12'h000;
   localparam logic [11:0] COLOR_RED   = 12'hF00;
   localparam logic [11:0] COLOR_GREEN = 12'h0F0;
   localparam logic [11:0] COLOR_BLUE  = 12'h00F;
   localparam logic [11:0] COLOR_WHITE = 12'hFFF;

   typedef enum logic [1:0] {
      OP_ADD   = 2'd0,
      OP_SET   = 2'd1,
      OP_DEL   = 2'd2,
      OP_CLEAR = 2'd3
   } cmd_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } tbl_state_e;

   function automatic logic [OBJ_W-1:0] make_obj(
      input logic [3:0]  e,
      input logic [9:0]  x,
      input logic [9:0]  y,
      input logic [9:0]  w,
      input logic [9:0]  h,
      input logic [9:0]  r,
      input logic [11:0] c);
      return {e, x, y, w, h, r, c};
   endfunction

endpackage

// File: rtl/obj_table_core.sv
// Work table: storage, length and the delete-compaction SHIFT FSM.
// Entries at index >= len are kept all-zero at all times.
module obj_table_core
   import obj_pkg::*;
#(
   parameter int OBJ_WIDTH = 66,
   parameter int MAX_LEN   = 16,
   parameter int LEN_BITS  = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [LEN_BITS-1:0]           cmd_idx,
   input  logic [OBJ_WIDTH-1:0]          cmd_obj,
   output logic                          cmd_err,
   output logic                          idle,
   output logic [OBJ_WIDTH*MAX_LEN-1:0]  work_packed,
   output logic [LEN_BITS-1:0]           work_len
);

   localparam int IDX_W = $clog2(MAX_LEN);

   tbl_state_e                          state_q, state_d;
   logic [MAX_LEN-1:0][OBJ_WIDTH-1:0]   ent_q, ent_d;
   logic [LEN_BITS-1:0]                 len_q, len_d;
   logic [LEN_BITS-1:0]                 ptr_q, ptr_d;
   logic                                err_q, err_d;
   logic [LEN_BITS-1:0]                 ptr_nxt;
   logic                                accept;

   assign idle      = (state_q == ST_IDLE);
   assign cmd_ready = idle && rst;
   assign accept    = cmd_valid && cmd_ready;
   assign ptr_nxt   = ptr_q + LEN_BITS'(1);

   always_comb begin
      state_d = state_q;
      ent_d   = ent_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op_e'(cmd_op))
                  OP_ADD: begin
                     if (len_q < LEN_BITS'(MAX_LEN)) begin
                        ent_d[len_q[IDX_W-1:0]] = cmd_obj;
                        len_d = len_q + LEN_BITS'(1);
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  OP_SET: begin
                     if (cmd_idx < len_q) ent_d[cmd_idx[IDX_W-1:0]] = cmd_obj;
                     else                 err_d = 1'b1;
                  end
                  OP_DEL: begin
                     if (cmd_idx < len_q) begin
                        ptr_d   = cmd_idx;
                        state_d = ST_SHIFT;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  OP_CLEAR: begin
                     ent_d = '0;
                     len_d = '0;
                  end
                  default: ;
               endcase
            end
         end
         ST_SHIFT: begin
            // Pull the tail down one slot per cycle; the last live slot is zeroed.
            if (ptr_q < len_q - LEN_BITS'(1)) begin
               ent_d[ptr_q[IDX_W-1:0]] = ent_q[ptr_nxt[IDX_W-1:0]];
               ptr_d = ptr_nxt;
            end else begin
               ent_d[ptr_q[IDX_W-1:0]] = '0;
               len_d   = len_q - LEN_BITS'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ent_q   <= '0;
         len_q   <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ent_q   <= ent_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   assign cmd_err     = err_q;
   assign work_packed = ent_q;
   assign work_len    = len_q;

endmodule

// File: rtl/obj_table_mgr.sv
// Shape-object table manager for the VGA renderer. Define OBJ_TABLE_DOUBLE_BUF_EN
// to present a shadow copy that only follows the work table at frame boundaries.
module obj_table_mgr
   import obj_pkg::*;
#(
   parameter int OBJ_WIDTH = 66,
   parameter int MAX_LEN   = 16,
   parameter int LEN_BITS  = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [LEN_BITS-1:0]           cmd_idx,
   input  logic [OBJ_WIDTH-1:0]          cmd_obj,
   output logic                          cmd_err,
   input  logic                          frame_start,
   output logic                          commit_done,
   output logic [OBJ_WIDTH*MAX_LEN-1:0]  obj_arr_packed,
   output logic [LEN_BITS-1:0]           arr_len
);

   logic [OBJ_WIDTH*MAX_LEN-1:0] work_packed;
   logic [LEN_BITS-1:0]          work_len;
   logic                         core_idle;

   obj_table_core #(
      .OBJ_WIDTH (OBJ_WIDTH),
      .MAX_LEN   (MAX_LEN),
      .LEN_BITS  (LEN_BITS)
   ) u_core (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_idx     (cmd_idx),
      .cmd_obj     (cmd_obj),
      .cmd_err     (cmd_err),
      .idle        (core_idle),
      .work_packed (work_packed),
      .work_len    (work_len)
   );

`ifdef OBJ_TABLE_DOUBLE_BUF_EN
   logic [OBJ_WIDTH*MAX_LEN-1:0] act_q, act_d;
   logic [LEN_BITS-1:0]          act_len_q, act_len_d;
   logic                         pending_q, pending_d;
   logic                         commit_q, commit_d;
   logic                         accept;
   logic                         commit;

   assign accept = cmd_valid && cmd_ready;
   // Copy only in a quiet idle cycle so a half-compacted table is never shown.
   assign commit = pending_q && core_idle && !accept;

   always_comb begin
      act_d     = act_q;
      act_len_d = act_len_q;
      pending_d = pending_q || frame_start;
      commit_d  = 1'b0;
      if (commit) begin
         act_d     = work_packed;
         act_len_d = work_len;
         pending_d = 1'b0;
         commit_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         act_q     <= '0;
         act_len_q <= '0;
         pending_q <= 1'b0;
         commit_q  <= 1'b0;
      end else begin
         act_q     <= act_d;
         act_len_q <= act_len_d;
         pending_q <= pending_d;
         commit_q  <= commit_d;
      end
   end

   assign obj_arr_packed = act_q;
   assign arr_len        = act_len_q;
   assign commit_done    = commit_q;
`else
   logic unused_frame;

   assign unused_frame   = frame_start ^ core_idle;
   assign obj_arr_packed = work_packed;
   assign arr_len        = work_len;
   assign commit_done    = 1'b0;
`endif

endmodule

// File: tb/tb_obj_table_mgr.sv
// Self-checking bench for obj_table_mgr against a queue-based table model.
module tb_obj_table_mgr;
   import obj_pkg::*;

   localparam int OW = 66;
   localparam int ML = 16;
   localparam int LB = 6;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [1:0]         cmd_op = 2'd0;
   logic [LB-1:0]      cmd_idx = '0;
   logic [OW-1:0]      cmd_obj = '0;
   logic               cmd_err;
   logic               frame_start = 1'b0;
   logic               commit_done;
   logic [OW*ML-1:0]   obj_arr_packed;
   logic [LB-1:0]      arr_len;

   int tests = 0;
   int fails = 0;

   logic [OW-1:0] m_work[$];
   logic [OW-1:0] m_act[$];

   always #5 clk = ~clk;

   obj_table_mgr #(.OBJ_WIDTH(OW), .MAX_LEN(ML), .LEN_BITS(LB)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_obj(cmd_obj), .cmd_err(cmd_err),
      .frame_start(frame_start), .commit_done(commit_done),
      .obj_arr_packed(obj_arr_packed), .arr_len(arr_len)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OW*ML-1:0] pack_q(input logic [OW-1:0] q[$]);
      logic [OW*ML-1:0] v;
      v = '0;
      for (int i = 0; i < q.size(); i++) v[i*OW +: OW] = q[i];
      return v;
   endfunction

   task automatic check_table(input string name);
      logic [OW*ML-1:0] exp_v;
      int               exp_len;
`ifdef OBJ_TABLE_DOUBLE_BUF_EN
      exp_v = pack_q(m_act);
      exp_len = m_act.size();
`else
      exp_v = pack_q(m_work);
      exp_len = m_work.size();
`endif
      tests++;
      if (arr_len !== LB'(exp_len)) begin
         fails++;
         $display("FAIL %s len: got %0d want %0d", name, arr_len, exp_len);
      end
      tests++;
      if (obj_arr_packed !== exp_v) begin
         fails++;
         for (int i = 0; i < ML; i++)
            if (obj_arr_packed[i*OW +: OW] !== exp_v[i*OW +: OW])
               $display("FAIL %s entry%0d: got %h want %h", name, i,
                        obj_arr_packed[i*OW +: OW], exp_v[i*OW +: OW]);
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         tests++; fails++;
         $display("FAIL %s ready timeout: got 0 want 1", name);
      end
   endtask

   task automatic do_cmd(input cmd_op_e op, input int idx, input logic [OW-1:0] obj,
                         input string name);
      logic exp_err = 1'b0;
      int   exp_busy = 0;
      int   n;
      wait_ready(name);
      case (op)
         OP_ADD:   if (m_work.size() < ML) m_work.push_back(obj); else exp_err = 1'b1;
         OP_SET:   if (idx < m_work.size()) m_work[idx] = obj; else exp_err = 1'b1;
         OP_DEL:   if (idx < m_work.size()) begin
                      exp_busy = m_work.size() - idx;
                      m_work.delete(idx);
                   end else exp_err = 1'b1;
         default:  m_work.delete();
      endcase
      cmd_valid = 1'b1; cmd_op = op; cmd_idx = LB'(idx); cmd_obj = obj;
      tick();
      cmd_valid = 1'b0; cmd_obj = {$urandom, $urandom, $urandom};
      tests++;
      if (cmd_err !== exp_err) begin
         fails++;
         $display("FAIL %s err: got %b want %b", name, cmd_err, exp_err);
      end
      if (exp_busy > 0) begin
         n = 0;
         while (cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
         tests++;
         if (n != exp_busy) begin
            fails++;
            $display("FAIL %s busy: got %0d want %0d", name, n, exp_busy);
         end
      end else if (exp_err) begin
         tick();
         tests++;
         if (cmd_err !== 1'b0) begin
            fails++;
            $display("FAIL %s err pulse width: got %b want 0", name, cmd_err);
         end
      end
      check_table(name);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      tests++;
      if (cmd_ready !== 1'b0 || cmd_err !== 1'b0 || commit_done !== 1'b0) begin
         fails++;
         $display("FAIL reset ctrl: got rdy=%b err=%b cd=%b want 0 0 0",
                  cmd_ready, cmd_err, commit_done);
      end
      check_table("reset");
      rst = 1'b1;
      #1;
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset release ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_add3();
      do_cmd(OP_ADD, 0, make_obj(RECTANGLE_ENUM, 10'd10, 10'd20, 10'd30, 10'd40, 10'd0, COLOR_RED), "add_rect");
      do_cmd(OP_ADD, 0, make_obj(CIRCLE_ENUM, 10'd100, 10'd120, 10'd0, 10'd0, 10'd25, COLOR_GREEN), "add_circle");
      do_cmd(OP_ADD, 0, make_obj(ROUNDRECT_ENUM, 10'd300, 10'd200, 10'd50, 10'd60, 10'd8, COLOR_WHITE), "add_rrect");
   endtask

   task automatic test_fill_overflow();
      while (m_work.size() < ML)
         do_cmd(OP_ADD, 0, {4'($urandom_range(1, 3)), 62'({$urandom, $urandom})}, "fill");
      do_cmd(OP_ADD, 0, {$urandom, $urandom, $urandom}, "add_full");
      do_cmd(OP_SET, 16, {$urandom, $urandom, $urandom}, "set_oob");
      do_cmd(OP_SET, 15, {$urandom, $urandom, $urandom}, "set_last");
   endtask

   task automatic test_del();
      do_cmd(OP_CLEAR, 0, '0, "clear");
      for (int i = 0; i < 5; i++)
         do_cmd(OP_ADD, 0, make_obj(RECTANGLE_ENUM, 10'(i), 10'(i), 10'd5, 10'd5, 10'd0, 12'(i + 1)), "del_setup");
      do_cmd(OP_DEL, 1, '0, "del_idx1");
      do_cmd(OP_DEL, 4, '0, "del_oob");
      do_cmd(OP_DEL, 3, '0, "del_last");
      do_cmd(OP_DEL, 0, '0, "del_first");
   endtask

   task automatic test_reset_mid_shift();
      do_cmd(OP_CLEAR, 0, '0, "clear2");
      for (int i = 0; i < 8; i++) do_cmd(OP_ADD, 0, {$urandom, $urandom, $urandom}, "rms_setup");
      wait_ready("rms");
      cmd_valid = 1'b1; cmd_op = OP_DEL; cmd_idx = '0;
      tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      m_work.delete();
      m_act.delete();
      tick();
      tests++;
      if (cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL rms ready in reset: got %b want 0", cmd_ready);
      end
      check_table("rms");
      rst = 1'b1;
      #1;
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL rms ready after release: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_random();
      int r, idx;
      for (int k = 0; k < 120; k++) begin
         r = $urandom_range(0, 9);
         idx = $urandom_range(0, m_work.size() + 1);
         if (r < 4)       do_cmd(OP_ADD, 0, {$urandom, $urandom, $urandom}, "rnd_add");
         else if (r < 6)  do_cmd(OP_SET, idx, {$urandom, $urandom, $urandom}, "rnd_set");
         else if (r < 9)  do_cmd(OP_DEL, idx, '0, "rnd_del");
         else             do_cmd(OP_CLEAR, 0, '0, "rnd_clear");
      end
   endtask

`ifdef OBJ_TABLE_DOUBLE_BUF_EN
   task automatic test_frame();
      int pulses;
      do_cmd(OP_CLEAR, 0, '0, "db_clear");
      // Resync the visible copy with a first commit.
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
      m_act = m_work;
      tests++;
      if (commit_done !== 1'b1) begin
         fails++;
         $display("FAIL db_sync commit_done: got %b want 1", commit_done);
      end
      tick();
      check_table("db_sync");
      do_cmd(OP_ADD, 0, make_obj(RECTANGLE_ENUM, 10'd1, 10'd2, 10'd3, 10'd4, 10'd0, COLOR_BLUE), "db_add1");
      do_cmd(OP_ADD, 0, make_obj(CIRCLE_ENUM, 10'd5, 10'd6, 10'd0, 10'd0, 10'd7, COLOR_RED), "db_add2");
      // Held for two cycles: the second pulse lands while pending and must be absorbed.
      pulses = 0;
      frame_start = 1'b1; tick();
      tick(); frame_start = 1'b0;
      if (commit_done === 1'b1) pulses++;
      m_act = m_work;
      check_table("db_commit");
      repeat (6) begin tick(); if (commit_done === 1'b1) pulses++; end
      tests++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL db_commit pulses: got %0d want 1", pulses);
      end
      do_cmd(OP_ADD, 0, {$urandom, $urandom, $urandom}, "db_add3");
      wait_ready("db_del");
      cmd_valid = 1'b1; cmd_op = OP_DEL; cmd_idx = '0;
      tick();
      cmd_valid = 1'b0;
      m_work.delete(0);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      pulses = 0;
      for (int n = 0; n < 50 && cmd_ready !== 1'b1; n++) begin
         if (commit_done === 1'b1) pulses++;
         tick();
      end
      if (commit_done === 1'b1) pulses++;
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL db_del early commit: got %0d want 0", pulses);
      end
      check_table("db_del_pre");
      tick();
      m_act = m_work;
      tests++;
      if (commit_done !== 1'b1) begin
         fails++;
         $display("FAIL db_del commit_done: got %b want 1", commit_done);
      end
      check_table("db_del_post");
   endtask
`else
   task automatic test_frame();
      int pulses = 0;
      do_cmd(OP_ADD, 0, {$urandom, $urandom, $urandom}, "nb_add");
      for (int k = 0; k < 6; k++) begin
         frame_start = k[0];
         tick();
         if (commit_done !== 1'b0) pulses++;
      end
      frame_start = 1'b0;
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL nb_commit_done: got %0d pulses want 0", pulses);
      end
      check_table("nb_after_frame");
   endtask
`endif

   initial begin
      test_reset();
      test_add3();
      test_fill_overflow();
      test_del();
      test_reset_mid_shift();
      test_frame();
      test_random();
      test_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
